// File: rtl/lbr_ring_unit_if.sv
// Bundle of pipeline-side signals for the last-branch-record ring:
// record capture, control, readout and status. The pipeline drives
// through the master modport and the ring unit receives through slave.
interface lbr_ring_unit_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int LBR_PTR_BITS = 4
);

  // Capture side
  logic                    stall;
  logic                    rec_valid;
  logic [1:0]              rec_type;
  logic [ADDRESS_BITS-1:0] rec_from;
  logic [ADDRESS_BITS-1:0] rec_to;

  // Control
  logic [2:0]              filter_mask;
  logic                    freeze_on_full;
  logic                    clear;

  // Readout request
  logic                    rd_req;
  logic [LBR_PTR_BITS-1:0] rd_index;
  logic                    rd_sel;

  // Readout result and status
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;
  logic                    rd_hit;
  logic [LBR_PTR_BITS:0]   count;
  logic                    overflow;
  logic                    frozen;

  modport master (
    output stall, rec_valid, rec_type, rec_from, rec_to,
    output filter_mask, freeze_on_full, clear,
    output rd_req, rd_index, rd_sel,
    input  rd_data, rd_valid, rd_hit, count, overflow, frozen
  );

  modport slave (
    input  stall, rec_valid, rec_type, rec_from, rec_to,
    input  filter_mask, freeze_on_full, clear,
    input  rd_req, rd_index, rd_sel,
    output rd_data, rd_valid, rd_hit, count, overflow, frozen
  );

endinterface

// File: rtl/lbr_ring_unit.sv
// Last-branch-record ring. Captures taken control transfers as from/to
// address pairs into a power-of-two ring, with per-type filtering,
// freeze-on-full or overwrite-oldest modes, a sticky overflow flag and a
// synchronous clear. Readout is by recency index through a registered
// one-cycle read port; a same-cycle write is never visible to that read.
module lbr_ring_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int LBR_PTR_BITS = 4
) (
  input  logic          clock,
  input  logic          reset,
  lbr_ring_unit_if.slave bus
);

  localparam int unsigned         DEPTH      = 2 ** LBR_PTR_BITS;
  localparam logic [LBR_PTR_BITS:0] FULL_COUNT = DEPTH[LBR_PTR_BITS:0];

  typedef enum logic [1:0] {
    REC_COND = 2'b00,
    REC_JAL  = 2'b01,
    REC_JALR = 2'b10,
    REC_RSVD = 2'b11
  } rec_type_e;

  // NOTE: the ring storage has no reset; count gates every read, so stale
  // entries are never observable and the arrays can map onto plain RAM.
  logic [ADDRESS_BITS-1:0] from_mem [DEPTH];
  logic [ADDRESS_BITS-1:0] to_mem   [DEPTH];

  logic [LBR_PTR_BITS-1:0] wr_ptr;
  logic [LBR_PTR_BITS:0]   count_q;
  logic                    overflow_q;
  logic                    frozen_q;

  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic                    rd_valid_q;
  logic                    rd_hit_q;

  logic                    type_enabled;
  logic                    full;
  logic                    accept;
  logic [LBR_PTR_BITS:0]   count_next;
  logic                    read_sample;
  logic [LBR_PTR_BITS-1:0] rd_ptr;
  logic                    read_hit;
  logic [ADDRESS_BITS-1:0] read_addr;

  // Per-type filter; the reserved encoding is never recorded.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    type_enabled = 1'b0;
    case (rec_type_e'(bus.rec_type))
      REC_COND: type_enabled = bus.filter_mask[0];
      REC_JAL:  type_enabled = bus.filter_mask[1];
      REC_JALR: type_enabled = bus.filter_mask[2];
      REC_RSVD: type_enabled = 1'b0;
      default:  type_enabled = 1'b0;
    endcase
  end

  assign full = (count_q == FULL_COUNT);

  // A record is dropped while frozen, and also on the cycle freeze mode is
  // raised on an already-full ring (frozen only takes effect next edge).
  assign accept = bus.rec_valid & ~bus.stall & ~frozen_q & type_enabled &
                  ~bus.clear & ~reset & ~(bus.freeze_on_full & full);

  // Occupancy after this edge, saturating at the ring depth.
  always_comb begin
    // NOTE: combinational logic uses blocking '='; registers below use '<='
    // so all state updates see pre-edge values.
    count_next = count_q;
    if (accept && !full) begin
      count_next = count_q + 1'b1;
    end
  end

  // Read addressing: most recent entry sits just behind the write pointer.
  assign read_sample = bus.rd_req & ~bus.stall;
  assign rd_ptr      = wr_ptr - LBR_PTR_BITS'(1) - bus.rd_index;
  assign read_hit    = ({1'b0, bus.rd_index} < count_q) & ~bus.clear;
  assign read_addr   = bus.rd_sel ? to_mem[rd_ptr] : from_mem[rd_ptr];

  // Ring storage write on accepted records.
  always_ff @(posedge clock) begin
    if (accept) begin
      from_mem[wr_ptr] <= bus.rec_from;
      to_mem[wr_ptr]   <= bus.rec_to;
    end
  end

  // Ring control state: pointer, occupancy, overflow and freeze flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      frozen_q   <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      frozen_q   <= 1'b0;
    end else if (!bus.stall) begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (full) begin
          overflow_q <= 1'b1;
        end
      end
      count_q  <= count_next;
      frozen_q <= bus.freeze_on_full & (count_next == FULL_COUNT);
    end
  end

  // Registered read port: one result per sampled request, next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
      rd_data_q  <= '0;
    end else if (read_sample) begin
      rd_valid_q <= 1'b1;
      rd_hit_q   <= read_hit;
      rd_data_q  <= read_hit ? DATA_WIDTH'(read_addr) : '0;
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_hit   = rd_hit_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.frozen   = frozen_q;

endmodule

// File: tb/tb_lbr_ring_unit.sv
// Directed bench for lbr_ring_unit (depth 16). Inputs change on the
// falling edge; outputs are checked on the following falling edge.
module tb_lbr_ring_unit;

  localparam int DW = 32;
  localparam int AB = 20;
  localparam int PB = 4;

  logic clock;
  logic reset;

  int checks;
  int failures;

  lbr_ring_unit_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB), .LBR_PTR_BITS(PB)) bus ();

  lbr_ring_unit #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB), .LBR_PTR_BITS(PB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic push(input logic [1:0] t, input logic [AB-1:0] f,
                      input logic [AB-1:0] to);
    bus.rec_valid = 1'b1;
    bus.rec_type  = t;
    bus.rec_from  = f;
    bus.rec_to    = to;
    tick();
    bus.rec_valid = 1'b0;
  endtask

  task automatic rd(input int idx, input logic sel);
    bus.rd_req   = 1'b1;
    bus.rd_index = PB'(idx);
    bus.rd_sel   = sel;
    tick();
    bus.rd_req   = 1'b0;
  endtask

  task automatic clear_ring();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset              = 1'b1;
    bus.stall          = 1'b0;
    bus.rec_valid      = 1'b0;
    bus.rec_type       = 2'b00;
    bus.rec_from       = '0;
    bus.rec_to         = '0;
    bus.filter_mask    = 3'b111;
    bus.freeze_on_full = 1'b0;
    bus.clear          = 1'b0;
    bus.rd_req         = 1'b0;
    bus.rd_index       = '0;
    bus.rd_sel         = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_count",    32'(bus.count),    32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_frozen",   32'(bus.frozen),   32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_hit",   32'(bus.rd_hit),   32'd0);
    check("rst_rd_data",  bus.rd_data,       32'd0);
    reset = 1'b0;

    // Three JAL records and basic readout
    push(2'b01, 20'h00100, 20'h00104);
    push(2'b01, 20'h00200, 20'h00204);
    push(2'b01, 20'h00300, 20'h00304);
    check("t1_count", 32'(bus.count), 32'd3);
    rd(0, 1'b1);
    check("t1_idx0_valid", 32'(bus.rd_valid), 32'd1);
    check("t1_idx0_hit",   32'(bus.rd_hit),   32'd1);
    check("t1_idx0_to",    bus.rd_data,       32'h00000304);
    rd(3, 1'b0);
    check("t1_idx3_valid", 32'(bus.rd_valid), 32'd1);
    check("t1_idx3_hit",   32'(bus.rd_hit),   32'd0);
    check("t1_idx3_data",  bus.rd_data,       32'd0);
    tick();
    check("t1_valid_pulse", 32'(bus.rd_valid), 32'd0);

    // Back-to-back reads
    bus.rd_req = 1'b1; bus.rd_sel = 1'b0; bus.rd_index = 4'd0;
    tick();
    check("b2b_first", bus.rd_data, 32'h00000300);
    bus.rd_index = 4'd2;
    tick();
    check("b2b_second_valid", 32'(bus.rd_valid), 32'd1);
    check("b2b_second", bus.rd_data, 32'h00000100);
    bus.rd_req = 1'b0;
    tick();
    check("b2b_end_valid", 32'(bus.rd_valid), 32'd0);

    // Overwrite mode: 20 records into a 16-deep ring
    clear_ring();
    check("t2_clear_count", 32'(bus.count), 32'd0);
    for (int i = 0; i < 20; i++) push(2'b00, AB'(i), AB'(i + 'h1000));
    check("t2_count",    32'(bus.count),    32'd16);
    check("t2_overflow", 32'(bus.overflow), 32'd1);
    check("t2_frozen",   32'(bus.frozen),   32'd0);
    rd(0, 1'b0);
    check("t2_idx0_from", bus.rd_data, 32'd19);
    rd(15, 1'b0);
    check("t2_idx15_from", bus.rd_data, 32'd4);
    rd(0, 1'b1);
    check("t2_idx0_to", bus.rd_data, 32'h1013);

    // Freeze-on-full mode
    clear_ring();
    check("t3_clear_overflow", 32'(bus.overflow), 32'd0);
    bus.freeze_on_full = 1'b1;
    for (int i = 0; i < 16; i++) push(2'b10, AB'(i), AB'(i + 'h2000));
    check("t3_frozen",   32'(bus.frozen),   32'd1);
    check("t3_count",    32'(bus.count),    32'd16);
    check("t3_overflow", 32'(bus.overflow), 32'd0);
    push(2'b10, 20'd16, 20'h2010);
    check("t3_drop_count",    32'(bus.count),    32'd16);
    check("t3_drop_overflow", 32'(bus.overflow), 32'd0);
    rd(0, 1'b0);
    check("t3_idx0_from", bus.rd_data, 32'd15);
    bus.freeze_on_full = 1'b0;
    tick();
    check("t3_unfrozen", 32'(bus.frozen), 32'd0);
    push(2'b10, 20'h00077, 20'h0007b);
    check("t3_resume_overflow", 32'(bus.overflow), 32'd1);
    check("t3_resume_count",    32'(bus.count),    32'd16);
    rd(0, 1'b0);
    check("t3_resume_idx0", bus.rd_data, 32'h77);
    rd(15, 1'b0);
    check("t3_resume_idx15", bus.rd_data, 32'd1);

    // Type filter: only conditional branches enabled
    clear_ring();
    bus.filter_mask = 3'b001;
    push(2'b01, 20'h00010, 20'h00014);
    push(2'b10, 20'h00020, 20'h00024);
    push(2'b00, 20'h00aaa, 20'h00aab);
    push(2'b11, 20'h00030, 20'h00034);
    check("t4_count", 32'(bus.count), 32'd1);
    rd(0, 1'b0);
    check("t4_idx0_from", bus.rd_data, 32'h00aaa);
    rd(1, 1'b0);
    check("t4_idx1_hit", 32'(bus.rd_hit), 32'd0);
    bus.filter_mask = 3'b111;
    push(2'b11, 20'h00040, 20'h00044);
    check("t4_rsvd_count", 32'(bus.count), 32'd1);

    // Record, clear and read in the same cycle
    bus.rec_valid = 1'b1; bus.rec_type = 2'b01;
    bus.rec_from = 20'h00bbb; bus.rec_to = 20'h00bbf;
    bus.clear = 1'b1;
    bus.rd_req = 1'b1; bus.rd_index = 4'd0; bus.rd_sel = 1'b0;
    tick();
    bus.rec_valid = 1'b0; bus.clear = 1'b0; bus.rd_req = 1'b0;
    check("t5_count",    32'(bus.count),    32'd0);
    check("t5_rd_valid", 32'(bus.rd_valid), 32'd1);
    check("t5_rd_hit",   32'(bus.rd_hit),   32'd0);
    check("t5_rd_data",  bus.rd_data,       32'd0);

    // Stall holds everything for three cycles
    push(2'b01, 20'h00555, 20'h00559);
    rd(0, 1'b1);
    check("t6_pre_data", bus.rd_data, 32'h00559);
    bus.stall = 1'b1;
    bus.rec_valid = 1'b1; bus.rec_type = 2'b01;
    bus.rec_from = 20'h00666; bus.rec_to = 20'h0066a;
    bus.rd_req = 1'b1; bus.rd_index = 4'd0; bus.rd_sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_stall_count", 32'(bus.count),    32'd1);
      check("t6_stall_valid", 32'(bus.rd_valid), 32'd0);
      check("t6_stall_data",  bus.rd_data,       32'h00559);
      check("t6_stall_hit",   32'(bus.rd_hit),   32'd1);
    end
    bus.stall = 1'b0; bus.rec_valid = 1'b0; bus.rd_req = 1'b0;
    rd(0, 1'b0);
    check("t6_post_idx0", bus.rd_data, 32'h00555);

    // Reset beats clear and a record
    clear_ring();
    for (int i = 1; i <= 5; i++) push(2'b00, AB'(i * 'h10), AB'(i * 'h10 + 4));
    check("t7_count", 32'(bus.count), 32'd5);
    rd(0, 1'b0);
    check("t7_pre_data", bus.rd_data, 32'h50);
    reset = 1'b1; bus.clear = 1'b1; bus.rec_valid = 1'b1; bus.rd_req = 1'b1;
    tick();
    reset = 1'b0; bus.clear = 1'b0; bus.rec_valid = 1'b0; bus.rd_req = 1'b0;
    check("t7_count_rst",    32'(bus.count),    32'd0);
    check("t7_overflow_rst", 32'(bus.overflow), 32'd0);
    check("t7_frozen_rst",   32'(bus.frozen),   32'd0);
    check("t7_valid_rst",    32'(bus.rd_valid), 32'd0);
    check("t7_hit_rst",      32'(bus.rd_hit),   32'd0);
    check("t7_data_rst",     bus.rd_data,       32'd0);
    rd(0, 1'b0);
    check("t7_post_hit", 32'(bus.rd_hit), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lbr_ring_unit.md
Name: lbr_ring_unit

Overview:
Parametrised last-branch-record buffer, successor to the fixed-size LBR in the memory/LBR stage. It sits beside the data-memory interface in the MEM stage and captures taken control transfers as from/to address pairs in a power-of-two ring. Per-type filtering, freeze-on-full or overwrite modes, sticky overflow and a synchronous clear are provided. Readout is by recency index with a registered, one-cycle read port that feeds the stage bypass mux.

Parameters:
DATA_WIDTH, 32, width of read data returned to the pipeline
ADDRESS_BITS, 20, width of recorded from/to addresses (must be <= DATA_WIDTH)
LBR_PTR_BITS, 4, log2 of ring depth; depth = 2**LBR_PTR_BITS (>= 1)

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  pipeline stall; blocks record capture and read sampling
rec_valid  input  1  a taken control transfer is presented this cycle
rec_type  input  2  00 cond branch, 01 JAL, 10 JALR, 11 reserved (never recorded)
rec_from  input  ADDRESS_BITS  PC of the transfer instruction
rec_to  input  ADDRESS_BITS  target address
filter_mask  input  3  bit[t]=1 enables recording of type t
freeze_on_full  input  1  1: stop recording when full; 0: overwrite oldest
clear  input  1  synchronous flush of ring state
rd_req  input  1  read request
rd_index  input  LBR_PTR_BITS  0 = most recent entry, 1 = next older, ...
rd_sel  input  1  0 returns from-address, 1 returns to-address
rd_data  output  DATA_WIDTH  zero-extended address, or 0 on miss
rd_valid  output  1  one-cycle pulse, read result present
rd_hit  output  1  qualifies rd_data; 1 when rd_index < count at sample time
count  output  LBR_PTR_BITS+1  valid entries, saturates at depth
overflow  output  1  sticky; an entry was overwritten
frozen  output  1  ring full in freeze mode, capture disabled

Behaviour:
- Reset: wr_ptr=0, count=0, overflow=0, frozen=0, rd_data=0, rd_valid=0, rd_hit=0. Storage arrays are not cleared; the count gates all reads.
- Accept condition: rec_valid & !stall & !frozen & rec_type!=11 & filter_mask[rec_type] & !clear & !reset.
- On accept, write {from,to} at wr_ptr, then wr_ptr <= wr_ptr+1 (mod depth, natural wrap).
  - If count < depth: count++.
  - If count == depth and freeze_on_full=0: overwrite the oldest entry, count holds, overflow <= 1.
- Freeze mode: when count reaches depth through an accept while freeze_on_full=1, frozen <= 1 on that edge. Later records are dropped silently.
  - Setting freeze_on_full while already full sets frozen on the next edge; no record is accepted that cycle.
  - Deasserting freeze_on_full clears frozen on the next edge; overwriting resumes.
- Clear: next edge sets wr_ptr=0, count=0, overflow=0, frozen=0. Clear beats a same-cycle record and a same-cycle read (rd_valid=1, rd_hit=0, rd_data=0). Reset beats clear.
- Read path:
  - Sampled when rd_req & !stall. Entry = (wr_ptr-1-rd_index) mod depth, using pre-edge wr_ptr and count.
  - A same-cycle write is not visible to that read (read-before-write).
  - Result is registered: rd_valid pulses exactly one cycle after sampling. rd_hit = (rd_index < count). rd_data = zero-extended selected address when hit, else 0.
  - Back-to-back reads give one result per cycle.
- Stall: no capture, no read sampling, rd_valid=0; rd_data, rd_hit, count and flags hold.
- rec_type 11 is never recorded regardless of filter_mask.

Test Plan:
- Reset, then 3 JAL records (from 0x00100/0x00200/0x00300, to +4) with filter_mask=111 -> count=3. Read idx0 sel1 -> next cycle rd_valid=1, rd_hit=1, rd_data=0x00000304. Read idx3 -> rd_hit=0, rd_data=0.
- Depth 16, overwrite mode, 20 records from=i -> count=16, overflow=1. idx0 from = 19; idx15 from = 4.
- freeze_on_full=1, 17 records -> frozen=1 after the 16th. The 17th is dropped and idx0 from = 15. Deassert freeze_on_full -> frozen=0 next cycle and the next record is captured.
- filter_mask=001 with JAL, JALR and branch records plus one type-11 record -> only the branch is recorded, count=1.
- Same cycle: record, clear and read -> count=0, rd_valid=1, rd_hit=0. Stall held 3 cycles with rec_valid=1 -> count unchanged and rd_valid=0.
- Reset asserted in the same cycle as clear and a record, with count=5 -> all outputs return to their reset values on the next cycle.
